// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction/PC, tracks occupancy and hold time.
// Optional performance counters (fetch_cnt, stall_cnt) are compiled in when IFID_PERF_EN is defined.
module if_id_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_F,
   input  logic [31:0] PC_F,
   input  logic        En_IFID,
   input  logic        stall_md,
   input  logic        flush_D,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC8_D,
   output logic        valid_D,
   output logic [1:0]  state_D,
   output logic [7:0]  hold_cnt,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned HOLD_W  = 8;
   localparam logic [DATA_W-1:0] RESET_PC = 32'h0000_3000;
   localparam logic [DATA_W-1:0] NOP      = 32'h0000_0000;
   localparam logic [HOLD_W-1:0] HOLD_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_VALID = 2'd1,
      ST_HELD  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_nxt;
   logic [HOLD_W-1:0] hold_nxt;
   logic              advance_c;

   // Same gating as the PC register so both stages stall together.
   assign advance_c = En_IFID && !stall_md;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_EMPTY;
         hold_cnt <= '0;
      end else begin
         state_q  <= state_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Next occupancy state and saturating hold counter; a hold overrides a flush.
   always_comb begin
      state_nxt = state_q;
      hold_nxt  = hold_cnt;
      if (advance_c) begin
         state_nxt = flush_D ? ST_EMPTY : ST_VALID;
         hold_nxt  = '0;
      end else begin
         case (state_q)
            ST_EMPTY: if (valid_D) state_nxt = ST_HELD;
            ST_VALID: if (valid_D) state_nxt = ST_HELD;
            ST_HELD:  state_nxt = ST_HELD;
            default:  state_nxt = ST_EMPTY;
         endcase
         if (state_nxt == ST_HELD && hold_cnt != HOLD_MAX)
            hold_nxt = hold_cnt + HOLD_W'(1);
      end
   end

   assign state_D = 2'(state_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Instr_D <= NOP;
         PC_D    <= RESET_PC;
         PC8_D   <= RESET_PC + DATA_W'(8);
         valid_D <= 1'b0;
      end else if (advance_c) begin
         Instr_D <= flush_D ? NOP : Instr_F;
         PC_D    <= PC_F;
         PC8_D   <= PC_F + DATA_W'(8);
         valid_D <= !flush_D;
      end
   end

`ifdef IFID_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (advance_c && !flush_D) fetch_cnt <= fetch_cnt + DATA_W'(1);
         if (!advance_c)            stall_cnt <= stall_cnt + DATA_W'(1);
      end
   end
`else
   assign fetch_cnt = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: reset, load, hold, flush-under-stall, PC+8 wrap, hold saturation.
module tb_if_id_reg;

`ifdef IFID_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr_F, PC_F;
   logic        En_IFID, stall_md, flush_D;
   logic [31:0] Instr_D, PC_D, PC8_D, fetch_cnt, stall_cnt;
   logic        valid_D;
   logic [1:0]  state_D;
   logic [7:0]  hold_cnt;

   int passed = 0;
   int total  = 0;

   if_id_reg dut (
      .clk(clk), .reset(reset), .Instr_F(Instr_F), .PC_F(PC_F),
      .En_IFID(En_IFID), .stall_md(stall_md), .flush_D(flush_D),
      .Instr_D(Instr_D), .PC_D(PC_D), .PC8_D(PC8_D), .valid_D(valid_D),
      .state_D(state_D), .hold_cnt(hold_cnt),
      .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] perf(input int unsigned n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic check_all(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] pc8, input logic vld, input logic [1:0] st,
                            input logic [7:0] hc);
      check({tag, ".instr"}, Instr_D, ins);
      check({tag, ".pc"},    PC_D,    pc);
      check({tag, ".pc8"},   PC8_D,   pc8);
      check({tag, ".valid"}, 32'(valid_D), 32'(vld));
      check({tag, ".state"}, 32'(state_D), 32'(st));
      check({tag, ".hold"},  32'(hold_cnt), 32'(hc));
   endtask

   initial begin
      reset = 1'b1; Instr_F = '0; PC_F = '0;
      En_IFID = 1'b0; stall_md = 1'b0; flush_D = 1'b0;
      #2;
      check_all("reset_async", 32'h0, 32'h3000, 32'h3008, 1'b0, 2'd0, 8'd0);
      check("reset_async.fetch", fetch_cnt, 32'd0);
      check("reset_async.stall", stall_cnt, 32'd0);

      @(negedge clk); reset = 1'b0;
      step();
      check_all("post_reset_idle", 32'h0, 32'h3000, 32'h3008, 1'b0, 2'd0, 8'd0);
      check("post_reset_idle.stall", stall_cnt, perf(1));

      Instr_F = 32'h8C01_0004; PC_F = 32'h3004; En_IFID = 1'b1;
      step();
      check_all("load", 32'h8C01_0004, 32'h3004, 32'h300C, 1'b1, 2'd1, 8'd0);
      check("load.fetch", fetch_cnt, perf(1));

      En_IFID = 1'b0; Instr_F = 32'hDEAD_BEEF; PC_F = 32'h4000;
      step(); step(); step();
      check_all("hold3", 32'h8C01_0004, 32'h3004, 32'h300C, 1'b1, 2'd2, 8'd3);
      check("hold3.stall", stall_cnt, perf(4));

      En_IFID = 1'b1; Instr_F = 32'h2402_0005; PC_F = 32'h3008;
      step();
      check_all("release", 32'h2402_0005, 32'h3008, 32'h3010, 1'b1, 2'd1, 8'd0);
      check("release.fetch", fetch_cnt, perf(2));

      flush_D = 1'b1; stall_md = 1'b1; Instr_F = 32'h1111_1111; PC_F = 32'h300C;
      step();
      check_all("flush_stalled", 32'h2402_0005, 32'h3008, 32'h3010, 1'b1, 2'd2, 8'd1);
      check("flush_stalled.stall", stall_cnt, perf(5));

      stall_md = 1'b0;
      step();
      check_all("flush", 32'h0, 32'h300C, 32'h3014, 1'b0, 2'd0, 8'd0);
      check("flush.fetch", fetch_cnt, perf(2));

      flush_D = 1'b0; En_IFID = 1'b0;
      step();
      check_all("empty_hold", 32'h0, 32'h300C, 32'h3014, 1'b0, 2'd0, 8'd0);

      En_IFID = 1'b1; Instr_F = 32'hAABB_CCDD; PC_F = 32'hFFFF_FFFC;
      step();
      check_all("wrap", 32'hAABB_CCDD, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 2'd1, 8'd0);
      check("wrap.fetch", fetch_cnt, perf(3));

      En_IFID = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300) begin
            check("sat.hold", 32'(hold_cnt), (k > 255) ? 32'hFF : 32'(k));
            check("sat.state", 32'(state_D), 32'd2);
            check("sat.fetch", fetch_cnt, perf(3));
            check("sat.stall", stall_cnt, perf(6 + k));
         end
      end
      check("sat.instr", Instr_D, 32'hAABB_CCDD);

      #2 reset = 1'b1;
      #1;
      check_all("reset_midhold", 32'h0, 32'h3000, 32'h3008, 1'b0, 2'd0, 8'd0);
      check("reset_midhold.fetch", fetch_cnt, 32'd0);
      check("reset_midhold.stall", stall_cnt, 32'd0);

      @(negedge clk); reset = 1'b0;
      step();
      check("post_midhold.state", 32'(state_D), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
